// File: rtl/seq_chain_ctrl.sv
// rtl/seq_chain_ctrl.sv - chained serial pattern hunter with per-stage timeout and result handshake
// Define SEQ_CHAIN_MATCH_CNT_EN to add the saturating match_cnt output.
module seq_chain_ctrl #(
    parameter int  SEQ_W      = 5,
    parameter int  NUM_STAGES = 4,
    parameter int  TMO_W      = 8,
    localparam int STG_W      = $clog2(NUM_STAGES)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cfg_we,
    input  logic [STG_W-1:0] cfg_addr,
    input  logic [SEQ_W-1:0] cfg_pat,
    input  logic [STG_W-1:0] cfg_last,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             start,
    input  logic             abort,
    input  logic             din,
    input  logic             din_valid,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [1:0]       res_status,
    output logic [STG_W-1:0] res_stage
`ifdef SEQ_CHAIN_MATCH_CNT_EN
    ,
    output logic [15:0]      match_cnt
`endif
);

    localparam int FILL_W = $clog2(SEQ_W + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HUNT   = 2'd1,
        S_RESULT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [SEQ_W-1:0]   r_table [NUM_STAGES];
    logic [SEQ_W-1:0]   r_seq;
    logic [FILL_W-1:0]  r_fill;
    logic [TMO_W-1:0]   r_timer;
    logic [STG_W-1:0]   r_stage;
    logic [STG_W-1:0]   r_last;
    logic [TMO_W-1:0]   r_tmo;
    logic [1:0]         r_res_status;
    logic [STG_W-1:0]   r_res_stage;

    logic [SEQ_W-1:0]   w_seq_next;
    logic [FILL_W-1:0]  w_fill_next;
    logic [TMO_W-1:0]   w_timer_next;
    logic               w_match;
    logic               w_tmo_hit;
    logic               w_res_load;
    logic [1:0]         w_res_status;
    logic               w_stage_adv;
    logic               w_cnt_inc;

    assign w_seq_next   = din_valid ? {r_seq[SEQ_W-2:0], din} : r_seq;
    assign w_fill_next  = (din_valid && (r_fill != FILL_W'(SEQ_W))) ? r_fill + 1'b1 : r_fill;
    // Fill guard: a stale all-zero shift register must not match before SEQ_W fresh bits.
    assign w_match      = din_valid && (w_fill_next == FILL_W'(SEQ_W)) &&
                          (w_seq_next == r_table[r_stage]);
    assign w_timer_next = r_timer + 1'b1;
    assign w_tmo_hit    = (r_tmo != '0) && (w_timer_next == r_tmo);

    assign busy       = (r_state != S_IDLE);
    assign res_valid  = (r_state == S_RESULT);
    assign res_status = r_res_status;
    assign res_stage  = r_res_stage;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority inside HUNT: abort, then match, then timeout.
    always_comb begin
        w_state_next = r_state;
        w_res_load   = 1'b0;
        w_res_status = 2'b00;
        w_stage_adv  = 1'b0;
        w_cnt_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_HUNT;
                end
            end
            S_HUNT: begin
                if (abort) begin
                    w_res_load   = 1'b1;
                    w_res_status = 2'b10;
                end else if (w_match) begin
                    w_cnt_inc = 1'b1;
                    if (r_stage == r_last) begin
                        w_res_load   = 1'b1;
                        w_res_status = 2'b00;
                    end else begin
                        w_stage_adv = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_res_load   = 1'b1;
                    w_res_status = 2'b01;
                end
                if (w_res_load) begin
                    w_state_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                r_table[i] <= '0;
            end
            r_seq        <= '0;
            r_fill       <= '0;
            r_timer      <= '0;
            r_stage      <= '0;
            r_last       <= '0;
            r_tmo        <= '0;
            r_res_status <= '0;
            r_res_stage  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_we) begin
                        r_table[cfg_addr] <= cfg_pat;
                    end
                    if (start) begin
                        r_last  <= cfg_last;
                        r_tmo   <= cfg_timeout;
                        r_seq   <= '0;
                        r_fill  <= '0;
                        r_stage <= '0;
                        r_timer <= '0;
                    end
                end
                S_HUNT: begin
                    // Shift register survives a stage advance so patterns may overlap.
                    r_seq   <= w_seq_next;
                    r_fill  <= w_fill_next;
                    r_timer <= w_stage_adv ? '0 : w_timer_next;
                    if (w_stage_adv) begin
                        r_stage <= r_stage + 1'b1;
                    end
                    if (w_res_load) begin
                        r_res_status <= w_res_status;
                        r_res_stage  <= r_stage;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEQ_CHAIN_MATCH_CNT_EN
    logic [15:0] r_match_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_match_cnt <= '0;
        end else if (w_cnt_inc && (r_match_cnt != 16'hFFFF)) begin
            r_match_cnt <= r_match_cnt + 16'd1;
        end
    end

    assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_seq_chain_ctrl.sv
// tb/tb_seq_chain_ctrl.sv - directed and randomized bench for seq_chain_ctrl against a bit-history model
module tb_seq_chain_ctrl;

    localparam int SEQ_W      = 5;
    localparam int NUM_STAGES = 4;
    localparam int TMO_W      = 8;
    localparam int STG_W      = 2;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             cfg_we = 1'b0;
    logic [STG_W-1:0] cfg_addr = '0;
    logic [SEQ_W-1:0] cfg_pat = '0;
    logic [STG_W-1:0] cfg_last = '0;
    logic [TMO_W-1:0] cfg_timeout = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             busy;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [1:0]       res_status;
    logic [STG_W-1:0] res_stage;
`ifdef SEQ_CHAIN_MATCH_CNT_EN
    logic [15:0]      match_cnt;
`endif

    seq_chain_ctrl #(
        .SEQ_W      (SEQ_W),
        .NUM_STAGES (NUM_STAGES),
        .TMO_W      (TMO_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_pat     (cfg_pat),
        .cfg_last    (cfg_last),
        .cfg_timeout (cfg_timeout),
        .start       (start),
        .abort       (abort),
        .din         (din),
        .din_valid   (din_valid),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_status  (res_status),
        .res_stage   (res_stage)
`ifdef SEQ_CHAIN_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bit history since start, current stage, cycles spent in the stage.
    bit m_bits[$];
    int m_pat [NUM_STAGES];
    int m_stage, m_tick, m_last, m_tmo, m_status, m_rstage, m_cnt;
    bit m_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit window_hits();
        int v = 0;
        if (m_bits.size() < SEQ_W) return 1'b0;
        for (int i = m_bits.size() - SEQ_W; i < m_bits.size(); i++) v = v * 2 + int'(m_bits[i]);
        return v == m_pat[m_stage];
    endfunction

    task automatic write_pat(input int a, input int p);
        cfg_we = 1'b1; cfg_addr = STG_W'(a); cfg_pat = SEQ_W'(p);
        tick();
        cfg_we = 1'b0;
        m_pat[a] = p;
    endtask

    task automatic do_start(input int l, input int t);
        cfg_last = STG_W'(l); cfg_timeout = TMO_W'(t); start = 1'b1;
        m_last = l; m_tmo = t; m_bits.delete(); m_stage = 0; m_tick = 0; m_done = 1'b0;
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_valid", res_valid, 0);
    endtask

    task automatic hunt(input bit v, input bit b, input bit ab, input string tag);
        bit hit;
        din_valid = v; din = b; abort = ab;
        if (!m_done) begin
            m_tick++;
            if (v) m_bits.push_back(b);
            hit = v && window_hits();
            if (ab) begin
                m_done = 1'b1; m_status = 2; m_rstage = m_stage;
            end else if (hit) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_stage == m_last) begin
                    m_done = 1'b1; m_status = 0; m_rstage = m_stage;
                end else begin
                    m_stage++; m_tick = 0;
                end
            end else if (m_tmo != 0 && m_tick == m_tmo) begin
                m_done = 1'b1; m_status = 1; m_rstage = m_stage;
            end
        end
        tick();
        din_valid = 1'b0; abort = 1'b0;
        check({tag, "_valid"}, res_valid, 32'(m_done));
        if (m_done) begin
            check({tag, "_status"}, res_status, m_status);
            check({tag, "_stage"}, res_stage, m_rstage);
        end
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("consume_valid", res_valid, 0);
        check("consume_busy", busy, 0);
`ifdef SEQ_CHAIN_MATCH_CNT_EN
        check("match_cnt", match_cnt, m_cnt);
`endif
    endtask

    task automatic feed(input int pat, input string tag);
        for (int i = SEQ_W - 1; i >= 0; i--) hunt(1'b1, pat[i], 1'b0, tag);
    endtask

    initial begin
        int first_k;
        for (int i = 0; i < NUM_STAGES; i++) m_pat[i] = 0;
        m_cnt = 0; m_done = 1'b0; m_status = 0; m_rstage = 0;

        tick(); tick();
        resetn = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_valid", res_valid, 0);
        check("rst_status", res_status, 0);
        check("rst_stage", res_stage, 0);

        // Basic chain with overlapped second stage
        write_pat(0, 5'b10110);
        write_pat(1, 5'b01101);
        do_start(1, 0);
        hunt(1, 1, 0, "basic"); hunt(1, 0, 0, "basic"); hunt(1, 1, 0, "basic");
        hunt(1, 1, 0, "basic"); hunt(1, 0, 0, "basic"); hunt(1, 1, 0, "basic");
        check("basic_done", res_valid, 1);
        check("basic_stage", res_stage, 1);
        consume();

        // Fill guard on an all-zero pattern
        write_pat(0, 0);
        do_start(0, 0);
        for (int i = 0; i < 5; i++) hunt(1, 0, 0, "fill");
        check("fill_done", res_status, 0);
        consume();

        // Timeout of 10 with no valid data
        do_start(0, 10);
        first_k = 0;
        for (int k = 1; k <= 12 && first_k == 0; k++) begin
            hunt(0, 0, 0, "tmo");
            if (res_valid === 1'b1) first_k = k;
        end
        check("tmo_edge", first_k, 10);
        check("tmo_status", res_status, 1);
        consume();

        // Timeout disabled: nothing for 300 cycles, then abort
        do_start(0, 0);
        for (int k = 0; k < 300; k++) hunt(0, 0, 0, "notmo");
        hunt(0, 0, 1, "notmo_abort");
        check("notmo_status", res_status, 2);
        consume();

        // Abort coinciding with the final-stage match
        write_pat(0, 5'b10110);
        write_pat(1, 5'b01101);
        do_start(1, 0);
        feed(5'b10110, "abm");
        hunt(1, 1, 1, "abm_final");
        check("abm_status", res_status, 2);
        check("abm_stage", res_stage, 1);

        // Backpressure with start and cfg_we pulsed while in RESULT
        for (int k = 0; k < 5; k++) begin
            start = 1'b1; cfg_we = 1'b1; cfg_addr = '0; cfg_pat = 5'b11111;
            tick();
            check("bp_valid", res_valid, 1);
            check("bp_status", res_status, 2);
            check("bp_stage", res_stage, 1);
        end
        start = 1'b0; cfg_we = 1'b0;
        consume();
        do_start(0, 0);
        feed(5'b10110, "tbl_kept");
        check("tbl_kept_done", res_valid, 1);
        consume();

        // Randomized chains against the model
        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < NUM_STAGES; a++) write_pat(a, int'($urandom_range(0, 31)));
            do_start(int'($urandom_range(0, 3)), ($urandom % 3 == 0) ? 0 : int'($urandom_range(15, 60)));
            for (int c = 0; c < 250 && !m_done; c++)
                hunt(($urandom % 4) != 0, $urandom % 2 == 1, ($urandom % 200) == 0, "rnd");
            if (!m_done) hunt(0, 0, 1, "rnd_abort");
            consume();
        end

        // Reset in the middle of a hunt at stage 1
        write_pat(0, 5'b11111);
        write_pat(1, 5'b00000);
        do_start(1, 0);
        feed(5'b11111, "mid");
        check("mid_busy", busy, 1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        for (int i = 0; i < NUM_STAGES; i++) m_pat[i] = 0;
        m_cnt = 0;
        check("mrst_busy", busy, 0);
        check("mrst_valid", res_valid, 0);
        check("mrst_status", res_status, 0);
        check("mrst_stage", res_stage, 0);
        do_start(0, 0);
        for (int i = 0; i < 5; i++) hunt(1, 0, 0, "post_rst");
        check("post_rst_done", res_valid, 1);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
